regfile_wb_arbiter: RTL and testbench

Write-back arbiter and pending-write scoreboard for the 32x32 register file. Two producers, the ALU path and the load path, compete for the register file's single write port. This block buffers one request per producer, grants the port with round-robin fairness, and drives the `regWrite`/`writeReg`/`writeData` inputs of the register file. It also tracks which architectural registers have an issued-but-unwritten result, so the decode stage can stall on read-after-write hazards.

---
 rtl/regfile_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: one holding slot per producer (ALU, load),
// round-robin grant of the single write port, and a pending-write scoreboard for decode.

module regfile_wb_slot #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          req_valid_i,
  input  logic [AW-1:0] req_reg_i,
  input  logic [DW-1:0] req_data_i,
  input  logic          gnt_i,
  output logic          hv_o,
  output logic [AW-1:0] hreg_o,
  output logic [DW-1:0] hdata_o
);
  logic          hv_q, hv_d;
  logic [AW-1:0] hreg_q, hreg_d;
  logic [DW-1:0] hdata_q, hdata_d;

  always_comb begin
    hv_d    = hv_q;
    hreg_d  = hreg_q;
    hdata_d = hdata_q;
    // A full slot only drains; accepts are possible only when empty (ready = !hv).
    if (gnt_i) begin
      hv_d = 1'b0;
    end else if (req_valid_i && !hv_q) begin
      hv_d    = (req_reg_i != '0);
      hreg_d  = req_reg_i;
      hdata_d = req_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      hv_q    <= 1'b0;
      hreg_q  <= '0;
      hdata_q <= '0;
    end else begin
      hv_q    <= hv_d;
      hreg_q  <= hreg_d;
      hdata_q <= hdata_d;
    end
  end

  assign hv_o    = hv_q;
  assign hreg_o  = hreg_q;
  assign hdata_o = hdata_q;
endmodule

module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          startin,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_reg,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_reg,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_reg,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          busy1,
  output logic          busy2,
  output logic          wr_en,
  output logic [AW-1:0] wr_reg,
  output logic [DW-1:0] wr_data,
  output logic          wr_src
);
  localparam int NSRC = 2;  // index 0 = ALU, 1 = load

  logic [NSRC-1:0]         req_valid, hv, gnt;
  logic [NSRC-1:0][AW-1:0] req_reg, hreg;
  logic [NSRC-1:0][DW-1:0] req_data, hdata;
  logic                    last_q, last_d;
  logic [NREG-1:0]         pend_q, pend_d;

  assign req_valid = {mem_valid, alu_valid};
  assign req_reg   = {mem_reg, alu_reg};
  assign req_data  = {mem_data, alu_data};

  for (genvar s = 0; s < NSRC; s++) begin : g_slot
    regfile_wb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk        (clk),
      .rst_i      (startin),
      .req_valid_i(req_valid[s]),
      .req_reg_i  (req_reg[s]),
      .req_data_i (req_data[s]),
      .gnt_i      (gnt[s]),
      .hv_o       (hv[s]),
      .hreg_o     (hreg[s]),
      .hdata_o    (hdata[s])
    );
  end

  // ALU wins unless load also holds and ALU was granted last; startin suppresses writes.
  always_comb begin
    gnt = '0;
    if (!startin) begin
      if (hv[0] && (!hv[1] || last_q)) gnt[0] = 1'b1;
      else if (hv[1])                  gnt[1] = 1'b1;
    end
  end

  assign wr_en   = |gnt;
  assign wr_src  = gnt[1];
  assign wr_reg  = gnt[1] ? hreg[1]  : (gnt[0] ? hreg[0]  : '0);
  assign wr_data = gnt[1] ? hdata[1] : (gnt[0] ? hdata[0] : '0);
  assign last_d  = wr_en ? gnt[1] : last_q;

  always_comb begin
    pend_d = pend_q;
    if (wr_en) pend_d[wr_reg] = 1'b0;
    // Set after clear: a freshly issued writer outranks the retiring one.
    if (rsv_valid && rsv_reg != '0) pend_d[rsv_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      last_q <= 1'b1;
      pend_q <= '0;
    end else begin
      last_q <= last_d;
      pend_q <= pend_d;
    end
  end

  assign alu_ready = !hv[0];
  assign mem_ready = !hv[1];
  assign busy1     = pend_q[rs1];
  assign busy2     = pend_q[rs2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin contention,
// r0 discard, scoreboard set/clear/collision and reset in mid-operation.

module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        startin;
  logic        alu_valid, mem_valid, rsv_valid;
  logic [4:0]  alu_reg, mem_reg, rsv_reg, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, busy1, busy2, wr_en, wr_src;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .startin(startin),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .rs1(rs1), .rs2(rs2),
    .busy1(busy1), .busy2(busy2),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .wr_src(wr_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after an edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; rsv_valid = 0;
    alu_reg = 0; mem_reg = 0; rsv_reg = 0;
    alu_data = 0; mem_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    startin = 1;
    tick();
    startin = 0;
  endtask

  initial begin
    idle_inputs();
    rs1 = 5; rs2 = 31;
    startin = 1;
    tick();
    settle();
    chk("wr_en_during_reset", wr_en, 0);
    tick();
    startin = 0;
    settle();
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_src", wr_src, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy2", busy2, 0);

    // Single ALU write
    alu_valid = 1; alu_reg = 3; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    settle();
    chk("alu_wr_en", wr_en, 1);
    chk("alu_wr_reg", wr_reg, 3);
    chk("alu_wr_data", wr_data, 32'hDEADBEEF);
    chk("alu_wr_src", wr_src, 0);
    chk("alu_ready_busy", alu_ready, 0);
    tick();
    chk("alu_ready_after", alu_ready, 1);
    chk("alu_wr_en_after", wr_en, 0);

    // Contention: ALU first after reset, then strict alternation with wr_en held high
    do_reset();
    alu_valid = 1; alu_reg = 4; alu_data = 32'h11;
    mem_valid = 1; mem_reg = 6; mem_data = 32'h22;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_wr_en_%0d", i), wr_en, 1);
      chk($sformatf("rr_src_%0d", i), wr_src, i % 2);
      chk($sformatf("rr_reg_%0d", i), wr_reg, (i % 2) ? 6 : 4);
      chk($sformatf("rr_data_%0d", i), wr_data, (i % 2) ? 32'h22 : 32'h11);
      tick();
    end

    // Register 0 requests are dropped
    do_reset();
    mem_valid = 1; mem_reg = 0; mem_data = 32'hFFFFFFFF;
    tick();
    mem_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r0_wr_en_%0d", i), wr_en, 0);
      chk($sformatf("r0_mem_ready_%0d", i), mem_ready, 1);
      tick();
    end

    // Scoreboard set, clear by write, and set-wins collision
    do_reset();
    rsv_valid = 1; rsv_reg = 7;
    tick();
    rsv_valid = 0; rs1 = 7; rs2 = 0;
    settle();
    chk("sb_busy1_set", busy1, 1);
    chk("sb_busy2_r0", busy2, 0);
    alu_valid = 1; alu_reg = 7; alu_data = 32'h77;
    tick();
    alu_valid = 0;
    chk("sb_wr_reg7", wr_reg, 7);
    chk("sb_busy_before_wr", busy1, 1);
    tick();
    chk("sb_busy_cleared", busy1, 0);
    rsv_valid = 1; rsv_reg = 7;
    tick();
    rsv_valid = 0;
    alu_valid = 1; alu_reg = 7; alu_data = 32'h78;
    tick();
    alu_valid = 0;
    chk("sb_coll_wr_en", wr_en, 1);
    rsv_valid = 1; rsv_reg = 7;
    tick();
    rsv_valid = 0;
    settle();
    chk("sb_set_wins", busy1, 1);
    chk("sb_coll_wr_done", wr_en, 0);

    // Reset mid-operation after ALU was last granted
    do_reset();
    alu_valid = 1; alu_reg = 2; alu_data = 32'h5;
    tick();
    alu_valid = 0;
    tick();
    alu_valid = 1; alu_reg = 4; alu_data = 32'h11;
    mem_valid = 1; mem_reg = 6; mem_data = 32'h22;
    rsv_valid = 1; rsv_reg = 9;
    tick();
    idle_inputs();
    rs1 = 9;
    settle();
    chk("mid_busy9", busy1, 1);
    chk("mid_both_held", {30'd0, alu_ready, mem_ready}, 0);
    startin = 1;
    settle();
    chk("mid_wr_en_startin", wr_en, 0);
    tick();
    startin = 0;
    settle();
    chk("mid_wr_en_after", wr_en, 0);
    chk("mid_busy_after", busy1, 0);
    chk("mid_ready_after", {30'd0, alu_ready, mem_ready}, 3);
    alu_valid = 1; alu_reg = 4; alu_data = 32'h11;
    mem_valid = 1; mem_reg = 6; mem_data = 32'h22;
    tick();
    idle_inputs();
    settle();
    chk("mid_tie_alu_first", wr_src, 0);
    chk("mid_tie_wr_en", wr_en, 1);
    tick();
    chk("mid_tie_second", wr_src, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
